p3_execute: RTL and testbench

//  Execute stage of the SIMPLE core; sits directly downstream of the p2 decode/register-read stage.

---
 rtl/p3_execute.sv | 171 +++++++++++++++++
 tb/tb_p3_execute.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/p3_execute.sv
// p3_execute: SIMPLE core execute stage -- ALU, S/Z/C/V flags, branch resolve, halt latch.
// Optional P3_MUL_EN adds a multi-cycle shift-add MUL on opcode 7; otherwise opcode 7 is a NOP.
module p3_execute #(
  parameter int W = 16
`ifdef P3_MUL_EN
  , parameter int MULCYC = 16
`endif
) (
  input  logic         clockp3,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] alu1,
  input  logic [W-1:0] alu2,
  input  logic [3:0]   opcode,
  input  logic         is_arith,
  input  logic [3:0]   shamt,
  input  logic         writereg,
  input  logic [1:0]   memwrite,
  input  logic [2:0]   regaddress,
  input  logic [W-1:0] address,
  input  logic [W-1:0] storedata,
  input  logic         isbranch,
  input  logic [2:0]   cond,
  input  logic [2:0]   subcond,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] inport,
  output logic         out_valid,
  output logic         busy,
  output logic [W-1:0] aluresult,
  output logic [3:0]   flags,
  output logic         writeregout,
  output logic [1:0]   memwriteout,
  output logic [2:0]   regaddressout,
  output logic [W-1:0] addressout,
  output logic [W-1:0] storedataout,
  output logic         branchtaken,
  output logic [W-1:0] branchtarget,
  output logic [W-1:0] outdata,
  output logic         outstrobe,
  output logic         haltout
);
  typedef enum logic [1:0] {IDLE, MUL, HALTED} state_t;
  state_t state, state_nx;
  logic accept, is_hlt, is_mul, wr_kill, flag_en, taken, sv, c, v, mul_done;
  logic [W-1:0] res;
  logic [W:0] sum, dif, sll, srl, sra;
  always_ff @(posedge clockp3 or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE && accept) ? (is_hlt ? HALTED : is_mul ? MUL : IDLE) :
               (state == MUL && mul_done) ? IDLE : state;
  always_comb begin
    accept = state == IDLE && in_valid;
    busy = state != IDLE;
  end
  always_comb begin
    sum = {1'b0, alu2} + {1'b0, alu1};
    dif = {1'b0, alu2} - {1'b0, alu1};
    // one extra bit on each shift captures the last bit shifted out
    sll = {1'b0, alu2} << shamt;
    srl = {alu2, 1'b0} >> shamt;
    sra = $signed({alu2, 1'b0}) >>> shamt;
    res = alu1;
    c = 1'b0;
    v = 1'b0;
    if (is_arith)
      case (opcode)
        4'd0: begin
          res = sum[W-1:0];
          c = sum[W];
          v = (alu2[W-1] == alu1[W-1]) && (sum[W-1] != alu2[W-1]);
        end
        4'd1, 4'd5: begin
          res = dif[W-1:0];
          c = dif[W];
          v = (alu2[W-1] != alu1[W-1]) && (dif[W-1] != alu2[W-1]);
        end
        4'd2: res = alu2 & alu1;
        4'd3: res = alu2 | alu1;
        4'd4: res = alu2 ^ alu1;
        4'd7: res = '0;
        4'd8: {c, res} = sll;
        4'd9: res = (alu2 << shamt) | (alu2 >> (5'(W) - {1'b0, shamt}));
        4'd10: {res, c} = srl;
        4'd11: {res, c} = sra;
        4'd12: res = inport;
        default: res = alu1;
      endcase
  end
  always_comb begin
    flag_en = is_arith && (opcode <= 4'd6 || (opcode >= 4'd8 && opcode <= 4'd11));
    is_hlt = is_arith && opcode == 4'd15;
`ifdef P3_MUL_EN
    is_mul = is_arith && opcode == 4'd7;
    wr_kill = is_hlt;
`else
    is_mul = 1'b0;
    wr_kill = is_hlt || (is_arith && opcode == 4'd7);
`endif
    sv = flags[3] ^ flags[0];
    taken = isbranch && (cond == 3'd4 || (cond == 3'd7 &&
            (subcond == 3'd0 ? flags[2] : subcond == 3'd1 ? sv :
             subcond == 3'd2 ? flags[2] | sv : subcond == 3'd3 ? !flags[2] : 1'b0)));
  end
`ifdef P3_MUL_EN
  localparam int CW = $clog2(MULCYC + 1);
  logic [W-1:0] acc, mcand, mplier, acc_nx;
  logic [CW-1:0] cnt;
  assign acc_nx = mplier[0] ? acc + mcand : acc;
  assign mul_done = state == MUL && cnt == CW'(MULCYC - 1);
  always_ff @(posedge clockp3 or posedge reset)
    if (reset) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (accept && is_mul) begin
      acc <= '0;
      mcand <= alu1;
      mplier <= alu2;
      cnt <= '0;
    end else if (state == MUL) begin
      acc <= acc_nx;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
    end
`else
  assign mul_done = 1'b0;
`endif
  always_ff @(posedge clockp3 or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      aluresult <= '0;
      flags <= '0;
      writeregout <= 1'b0;
      memwriteout <= '0;
      regaddressout <= '0;
      addressout <= '0;
      storedataout <= '0;
      branchtaken <= 1'b0;
      branchtarget <= '0;
      outdata <= '0;
      outstrobe <= 1'b0;
      haltout <= 1'b0;
    end else begin
      out_valid <= accept && !is_mul;
      outstrobe <= accept && is_arith && opcode == 4'd13;
      branchtaken <= accept && taken;
      if (accept) begin
        aluresult <= res;
        writeregout <= writereg && !wr_kill;
        memwriteout <= memwrite;
        regaddressout <= regaddress;
        addressout <= address;
        storedataout <= storedata;
        branchtarget <= pc_in + address;
        if (flag_en) flags <= {res[W-1], res == '0, c, v};
        if (is_arith && opcode == 4'd13) outdata <= alu1;
        if (is_hlt) haltout <= 1'b1;
      end
`ifdef P3_MUL_EN
      if (mul_done) begin
        out_valid <= 1'b1;
        aluresult <= acc_nx;
        flags <= {acc_nx[W-1], acc_nx == '0, 2'b00};
      end
`endif
    end
endmodule

// File: tb/tb_p3_execute.sv
// tb_p3_execute: directed vectors for p3_execute with a queue scoreboard checked on out_valid.
module tb_p3_execute;
  logic clockp3 = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [15:0] alu1 = '0, alu2 = '0, address = '0, storedata = '0, pc_in = '0, inport = 16'hBEEF;
  logic [3:0] opcode = '0, shamt = '0;
  logic is_arith = 1'b0, writereg = 1'b0, isbranch = 1'b0;
  logic [1:0] memwrite = '0;
  logic [2:0] regaddress = '0, cond = '0, subcond = '0;
  logic out_valid, busy, writeregout, branchtaken, outstrobe, haltout;
  logic [15:0] aluresult, addressout, storedataout, branchtarget, outdata;
  logic [3:0] flags;
  logic [1:0] memwriteout;
  logic [2:0] regaddressout;

  p3_execute dut (
    .clockp3(clockp3), .reset(reset), .in_valid(in_valid), .alu1(alu1), .alu2(alu2),
    .opcode(opcode), .is_arith(is_arith), .shamt(shamt), .writereg(writereg),
    .memwrite(memwrite), .regaddress(regaddress), .address(address), .storedata(storedata),
    .isbranch(isbranch), .cond(cond), .subcond(subcond), .pc_in(pc_in), .inport(inport),
    .out_valid(out_valid), .busy(busy), .aluresult(aluresult), .flags(flags),
    .writeregout(writeregout), .memwriteout(memwriteout), .regaddressout(regaddressout),
    .addressout(addressout), .storedataout(storedataout), .branchtaken(branchtaken),
    .branchtarget(branchtarget), .outdata(outdata), .outstrobe(outstrobe), .haltout(haltout)
  );

  always #5 clockp3 = ~clockp3;

  typedef struct {
    string nm;
    logic [15:0] res, tgt, od, adr, sd;
    logic [3:0] fl;
    logic [1:0] mw;
    logic [2:0] ra;
    logic wr, bt, os, h;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", nm, act, req);
    end
  endtask

  always @(negedge clockp3) begin : monitor
    exp_t e;
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid got aluresult=%h required no output", aluresult);
      end else begin
        e = q.pop_front();
        chk({e.nm, ".res"}, aluresult, e.res);
        chk({e.nm, ".flags"}, 16'(flags), 16'(e.fl));
        chk({e.nm, ".wr"}, 16'(writeregout), 16'(e.wr));
        chk({e.nm, ".mw"}, 16'(memwriteout), 16'(e.mw));
        chk({e.nm, ".ra"}, 16'(regaddressout), 16'(e.ra));
        chk({e.nm, ".adr"}, addressout, e.adr);
        chk({e.nm, ".sd"}, storedataout, e.sd);
        chk({e.nm, ".taken"}, 16'(branchtaken), 16'(e.bt));
        chk({e.nm, ".target"}, branchtarget, e.tgt);
        chk({e.nm, ".strobe"}, 16'(outstrobe), 16'(e.os));
        chk({e.nm, ".halt"}, 16'(haltout), 16'(e.h));
        if (e.os) chk({e.nm, ".outdata"}, outdata, e.od);
      end
    end
  end

  task automatic issue(input string nm, input logic ar, input logic [3:0] op,
                       input logic [15:0] a2, input logic [15:0] a1, input logic [3:0] sh,
                       input logic isb, input logic [2:0] cn, input logic [2:0] sc,
                       input logic [15:0] pc, input logic [15:0] adr, input logic [15:0] e_res,
                       input logic [3:0] e_fl, input logic e_wr, input logic e_bt,
                       input logic [15:0] e_tgt);
    exp_t e;
    in_valid = 1'b1;
    is_arith = ar;
    opcode = op;
    alu2 = a2;
    alu1 = a1;
    shamt = sh;
    isbranch = isb;
    cond = cn;
    subcond = sc;
    pc_in = pc;
    address = adr;
    writereg = 1'b1;
    memwrite = op[1:0];
    regaddress = op[2:0] ^ 3'd5;
    storedata = a2 ^ 16'hA5A5;
    e.nm = nm;
    e.res = e_res;
    e.fl = e_fl;
    e.wr = e_wr;
    e.bt = e_bt;
    e.tgt = e_tgt;
    e.od = a1;
    e.os = ar && op == 4'd13;
    e.h = ar && op == 4'd15;
    e.mw = op[1:0];
    e.ra = op[2:0] ^ 3'd5;
    e.adr = adr;
    e.sd = a2 ^ 16'hA5A5;
    q.push_back(e);
    @(negedge clockp3);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clockp3);
    chk("drain_pending", 16'(q.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clockp3);
    chk("rst.out_valid", 16'(out_valid), 16'd0);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.flags", 16'(flags), 16'd0);
    chk("rst.res", aluresult, 16'd0);
    chk("rst.halt", 16'(haltout), 16'd0);
    chk("rst.wr", 16'(writeregout), 16'd0);
    reset = 1'b0;
    @(negedge clockp3);
    //     name       ar op  alu2     alu1     sh b  cn sc pc       adr      res      flags    wr bt target
    issue("add_ovf",  1, 0,  'h7FFF,  'h0001,  0, 0, 0, 0, 0,       0,       'h8000,  'b1001,  1, 0, 0);
    issue("cmp_eq",   1, 5,  'h0005,  'h0005,  0, 0, 0, 0, 0,       0,       'h0000,  'b0100,  1, 0, 0);
    issue("br_z",     0, 0,  0,       'h1234,  0, 1, 7, 0, 'h0010,  'hFFFC,  'h1234,  'b0100,  1, 1, 'h000C);
    issue("br_nz",    0, 0,  0,       0,       0, 1, 7, 3, 'h0100,  'h0020,  0,       'b0100,  1, 0, 'h0120);
    issue("sra",      1, 11, 'h8001,  0,       1, 0, 0, 0, 0,       0,       'hC000,  'b1010,  1, 0, 0);
    issue("br_le",    0, 0,  0,       0,       0, 1, 7, 2, 'h0200,  0,       0,       'b1010,  1, 1, 'h0200);
    issue("slr",      1, 9,  'h8001,  0,       4, 0, 0, 0, 0,       0,       'h0018,  'b0000,  1, 0, 0);
    issue("sub_brw",  1, 1,  'h0003,  'h0005,  0, 0, 0, 0, 0,       0,       'hFFFE,  'b1010,  1, 0, 0);
    issue("sll",      1, 8,  'hC001,  0,       2, 0, 0, 0, 0,       0,       'h0004,  'b0010,  1, 0, 0);
    issue("srl0",     1, 10, 'h8001,  0,       0, 0, 0, 0, 0,       0,       'h8001,  'b1000,  1, 0, 0);
    issue("add_cv",   1, 0,  'h8000,  'h8000,  0, 0, 0, 0, 0,       0,       'h0000,  'b0111,  1, 0, 0);
    issue("br_lt",    0, 0,  0,       0,       0, 1, 7, 1, 'h1000,  'h0010,  0,       'b0111,  1, 1, 'h1010);
    issue("br_sc4",   0, 0,  0,       0,       0, 1, 7, 4, 0,       0,       0,       'b0111,  1, 0, 0);
    issue("br_al",    0, 0,  0,       0,       0, 1, 4, 0, 'hFFFF,  'h0002,  0,       'b0111,  1, 1, 'h0001);
    issue("br_c5",    0, 0,  0,       0,       0, 1, 5, 0, 0,       0,       0,       'b0111,  1, 0, 0);
    issue("xor",      1, 4,  'h00FF,  'h00FF,  0, 0, 0, 0, 0,       0,       'h0000,  'b0100,  1, 0, 0);
    issue("or",       1, 3,  'h1200,  'h0034,  0, 0, 0, 0, 0,       0,       'h1234,  'b0000,  1, 0, 0);
    issue("and",      1, 2,  'hF0F0,  'h0FF0,  0, 0, 0, 0, 0,       0,       'h00F0,  'b0000,  1, 0, 0);
    issue("mov",      1, 6,  0,       'h8000,  0, 0, 0, 0, 0,       0,       'h8000,  'b1000,  1, 0, 0);
    issue("nop7",     1, 7,  'h2222,  'h1111,  0, 0, 0, 0, 0,       0,       'h0000,  'b1000,  0, 0, 0);
    issue("in",       1, 12, 0,       0,       0, 0, 0, 0, 0,       0,       'hBEEF,  'b1000,  1, 0, 0);
    issue("out",      1, 13, 0,       'h0042,  0, 0, 0, 0, 0,       0,       'h0042,  'b1000,  1, 0, 0);
    issue("hlt",      1, 15, 0,       0,       0, 0, 0, 0, 0,       0,       'h0000,  'b1000,  0, 0, 0);
    chk("hlt.busy", 16'(busy), 16'd1);
    in_valid = 1'b1;
    is_arith = 1'b1;
    opcode = 4'd0;
    alu2 = 16'h0001;
    alu1 = 16'h0001;
    repeat (3) @(negedge clockp3);
    in_valid = 1'b0;
    chk("halted.busy", 16'(busy), 16'd1);
    chk("halted.halt", 16'(haltout), 16'd1);
    drain();
    #2 reset = 1'b1;
    #1;
    chk("arst.halt", 16'(haltout), 16'd0);
    chk("arst.busy", 16'(busy), 16'd0);
    chk("arst.flags", 16'(flags), 16'd0);
    chk("arst.out_valid", 16'(out_valid), 16'd0);
    @(negedge clockp3);
    reset = 1'b0;
    issue("add_after", 1, 0, 'h0001, 'h0001, 0, 0, 0, 0, 'h0003, 'h0004, 'h0002, 'b0000, 1, 0, 'h0007);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
